// File: rtl/rob_pkg.sv
// Shared definitions for the multi-commit reorder buffer: op encodings, the
// per-entry record and small op-classification helpers.
package rob_pkg;

    typedef enum logic [2:0] {
        OP_WRITE   = 3'd0,
        OP_JUMP    = 3'd1,
        OP_BOTH    = 3'd2,
        OP_LOAD    = 3'd3,
        OP_STORE   = 3'd4,
        OP_NOTHING = 3'd5
    } rob_op_e;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        redirect;
        rob_op_e     op;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] jump;
    } rob_entry_t;

    function automatic logic op_writes_rd(input rob_op_e op);
        return (op == OP_WRITE) || (op == OP_LOAD) || (op == OP_BOTH);
    endfunction

    function automatic logic op_redirects(input rob_op_e op);
        return (op == OP_JUMP) || (op == OP_BOTH);
    endfunction

endpackage

// File: rtl/rob_mc_if.sv
// Bundle of the ROB's allocation, writeback, commit and query signals.
// master = decoder/RS/LSB/regfile side, slave = the ROB itself.
interface rob_mc_if #(
    parameter int ROB_WIDTH = 4,
    parameter int COMMIT_W  = 2,
    parameter int NQ        = 2
);
    logic                          alloc_valid;
    logic [2:0]                    alloc_op;
    logic [4:0]                    alloc_rd;
    logic                          alloc_ready;
    logic [ROB_WIDTH-1:0]          alloc_tag;

    logic                          rs_wb_valid;
    logic [ROB_WIDTH-1:0]          rs_wb_tag;
    logic [31:0]                   rs_wb_wdata;
    logic [31:0]                   rs_wb_jump;
    logic                          rs_wb_redirect;

    logic                          lsb_wb_valid;
    logic [ROB_WIDTH-1:0]          lsb_wb_tag;
    logic [31:0]                   lsb_wb_wdata;

    logic [COMMIT_W-1:0]           cm_valid;
    logic [5*COMMIT_W-1:0]         cm_rd;
    logic [32*COMMIT_W-1:0]        cm_wdata;
    logic [ROB_WIDTH*COMMIT_W-1:0] cm_tag;

    logic                          to_lsb;
    logic [ROB_WIDTH-1:0]          to_lsb_tag;
    logic                          flush;
    logic [31:0]                   flush_pc;

    logic [ROB_WIDTH*NQ-1:0]       qry_tag;
    logic [NQ-1:0]                 qry_ready;
    logic [32*NQ-1:0]              qry_data;

    logic [ROB_WIDTH:0]            count;

    modport master (
        output alloc_valid, alloc_op, alloc_rd,
        output rs_wb_valid, rs_wb_tag, rs_wb_wdata, rs_wb_jump, rs_wb_redirect,
        output lsb_wb_valid, lsb_wb_tag, lsb_wb_wdata,
        output qry_tag,
        input  alloc_ready, alloc_tag,
        input  cm_valid, cm_rd, cm_wdata, cm_tag,
        input  to_lsb, to_lsb_tag, flush, flush_pc,
        input  qry_ready, qry_data, count
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rd,
        input  rs_wb_valid, rs_wb_tag, rs_wb_wdata, rs_wb_jump, rs_wb_redirect,
        input  lsb_wb_valid, lsb_wb_tag, lsb_wb_wdata,
        input  qry_tag,
        output alloc_ready, alloc_tag,
        output cm_valid, cm_rd, cm_wdata, cm_tag,
        output to_lsb, to_lsb_tag, flush, flush_pc,
        output qry_ready, qry_data, count
    );

endinterface

// File: rtl/rob_commit_sel.sv
// In-order prefix selector: a slot retires only if it and every older slot are
// retirable; the scan stops after the first store or the first redirect.
module rob_commit_sel #(
    parameter  int COMMIT_W = 2,
    localparam int SW       = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
    input  logic [COMMIT_W-1:0] slot_ok,
    input  logic [COMMIT_W-1:0] slot_store,
    input  logic [COMMIT_W-1:0] slot_redir,
    output logic [COMMIT_W-1:0] retire,
    output logic                store_hit,
    output logic [SW-1:0]       store_slot,
    output logic                redir_hit,
    output logic [SW-1:0]       redir_slot
);

    logic go;

    always_comb begin
        retire     = '0;
        store_hit  = 1'b0;
        store_slot = '0;
        redir_hit  = 1'b0;
        redir_slot = '0;
        go         = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            retire[i] = go & slot_ok[i];
            if (retire[i] && slot_store[i]) begin
                store_hit  = 1'b1;
                store_slot = SW'(i);
            end
            if (retire[i] && slot_redir[i]) begin
                redir_hit  = 1'b1;
                redir_slot = SW'(i);
            end
            go = go & slot_ok[i] & ~slot_store[i] & ~slot_redir[i];
        end
    end

endmodule

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer: in-order allocation, out-of-order writeback,
// up to COMMIT_W in-order retirements per cycle with store tokens and flush.
module rob_mc
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int COMMIT_W  = 2,
    parameter int NQ        = 2
) (
    input  logic    clk_in,
    input  logic    rst_n_in,
    input  logic    rdy_in,
    rob_mc_if.slave bus
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam int SW    = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

    typedef logic [ROB_WIDTH-1:0] idx_t;
    typedef logic [ROB_WIDTH:0]   ptr_t;

    rob_entry_t ent_q [DEPTH];
    rob_entry_t ent_d [DEPTH];
    ptr_t       head_q, head_d, tail_q, tail_d;

    logic [COMMIT_W-1:0]           cm_valid_q, cm_valid_d;
    logic [5*COMMIT_W-1:0]         cm_rd_q, cm_rd_d;
    logic [32*COMMIT_W-1:0]        cm_wdata_q, cm_wdata_d;
    logic [ROB_WIDTH*COMMIT_W-1:0] cm_tag_q, cm_tag_d;
    logic                          to_lsb_q, to_lsb_d;
    idx_t                          to_lsb_tag_q, to_lsb_tag_d;
    logic                          flush_q, flush_d;
    logic [31:0]                   flush_pc_q, flush_pc_d;

    ptr_t count_w;
    logic alloc_ready_w;
    logic alloc_fire;

    idx_t                slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0] slot_ok, slot_store, slot_redir, retire;
    logic                store_hit, redir_hit;
    logic [SW-1:0]       store_slot, redir_slot;

    logic [NQ-1:0]       qry_ready_w;
    logic [32*NQ-1:0]    qry_data_w;

    function automatic ptr_t count_ones(input logic [COMMIT_W-1:0] v);
        ptr_t n = '0;
        for (int i = 0; i < COMMIT_W; i++) n = n + ptr_t'(v[i]);
        return n;
    endfunction

    // Full when the index bits match but the wrap bits differ, i.e. count's MSB.
    assign count_w       = tail_q - head_q;
    assign alloc_ready_w = !count_w[ROB_WIDTH] && !flush_q;
    assign alloc_fire    = bus.alloc_valid && alloc_ready_w;

    always_comb begin
        slot_ok    = '0;
        slot_store = '0;
        slot_redir = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot_idx[i]   = head_q[ROB_WIDTH-1:0] + idx_t'(i);
            slot_ok[i]    = ent_q[slot_idx[i]].valid && ent_q[slot_idx[i]].ready && !flush_q;
            slot_store[i] = (ent_q[slot_idx[i]].op == OP_STORE);
            slot_redir[i] = ent_q[slot_idx[i]].redirect || op_redirects(ent_q[slot_idx[i]].op);
        end
    end

    rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_commit_sel (
        .slot_ok    (slot_ok),
        .slot_store (slot_store),
        .slot_redir (slot_redir),
        .retire     (retire),
        .store_hit  (store_hit),
        .store_slot (store_slot),
        .redir_hit  (redir_hit),
        .redir_slot (redir_slot)
    );

    always_comb begin
        ent_d        = ent_q;
        head_d       = head_q + count_ones(retire);
        tail_d       = tail_q;
        cm_valid_d   = '0;
        cm_rd_d      = '0;
        cm_wdata_d   = '0;
        cm_tag_d     = '0;
        to_lsb_d     = store_hit;
        to_lsb_tag_d = store_hit ? slot_idx[store_slot] : '0;
        flush_d      = redir_hit;
        flush_pc_d   = redir_hit ? ent_q[slot_idx[redir_slot]].jump : 32'h0;

        for (int i = 0; i < COMMIT_W; i++) begin
            if (retire[i]) begin
                ent_d[slot_idx[i]].valid         = 1'b0;
                cm_valid_d[i]                    = 1'b1;
                cm_tag_d[i*ROB_WIDTH +: ROB_WIDTH] = slot_idx[i];
                if (op_writes_rd(ent_q[slot_idx[i]].op)) begin
                    cm_rd_d[i*5 +: 5]     = ent_q[slot_idx[i]].rd;
                    cm_wdata_d[i*32 +: 32] = ent_q[slot_idx[i]].wdata;
                end
            end
        end

        // Writebacks are dropped during the flush cycle; LSB applied last so it wins.
        if (!flush_q) begin
            if (bus.rs_wb_valid) begin
                ent_d[bus.rs_wb_tag].wdata    = bus.rs_wb_wdata;
                ent_d[bus.rs_wb_tag].jump     = bus.rs_wb_jump;
                ent_d[bus.rs_wb_tag].redirect = bus.rs_wb_redirect;
                if (ent_q[bus.rs_wb_tag].op != OP_LOAD) ent_d[bus.rs_wb_tag].ready = 1'b1;
            end
            if (bus.lsb_wb_valid) begin
                ent_d[bus.lsb_wb_tag].wdata = bus.lsb_wb_wdata;
                ent_d[bus.lsb_wb_tag].ready = 1'b1;
            end
        end

        if (alloc_fire) begin
            ent_d[tail_q[ROB_WIDTH-1:0]] = '{valid: 1'b1, ready: 1'b0, redirect: 1'b0,
                                             op: rob_op_e'(bus.alloc_op), rd: bus.alloc_rd,
                                             wdata: 32'h0, jump: 32'h0};
            tail_d = tail_q + ptr_t'(1);
        end

        if (redir_hit) begin
            head_d = '0;
            tail_d = '0;
            for (int j = 0; j < DEPTH; j++) ent_d[j].valid = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cm_valid_q   <= '0;
            cm_rd_q      <= '0;
            cm_wdata_q   <= '0;
            cm_tag_q     <= '0;
            to_lsb_q     <= 1'b0;
            to_lsb_tag_q <= '0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
        end else if (rdy_in) begin
            for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
            head_q       <= head_d;
            tail_q       <= tail_d;
            cm_valid_q   <= cm_valid_d;
            cm_rd_q      <= cm_rd_d;
            cm_wdata_q   <= cm_wdata_d;
            cm_tag_q     <= cm_tag_d;
            to_lsb_q     <= to_lsb_d;
            to_lsb_tag_q <= to_lsb_tag_d;
            flush_q      <= flush_d;
            flush_pc_q   <= flush_pc_d;
        end
    end

    // Operand queries read settled entry state only; no same-cycle writeback bypass.
    always_comb begin
        qry_ready_w = '0;
        qry_data_w  = '0;
        for (int k = 0; k < NQ; k++) begin
            qry_ready_w[k]         = ent_q[bus.qry_tag[k*ROB_WIDTH +: ROB_WIDTH]].valid &&
                                     ent_q[bus.qry_tag[k*ROB_WIDTH +: ROB_WIDTH]].ready;
            qry_data_w[k*32 +: 32] = ent_q[bus.qry_tag[k*ROB_WIDTH +: ROB_WIDTH]].wdata;
        end
    end

    assign bus.alloc_ready = alloc_ready_w;
    assign bus.alloc_tag   = tail_q[ROB_WIDTH-1:0];
    assign bus.count       = count_w;
    assign bus.cm_valid    = cm_valid_q;
    assign bus.cm_rd       = cm_rd_q;
    assign bus.cm_wdata    = cm_wdata_q;
    assign bus.cm_tag      = cm_tag_q;
    assign bus.to_lsb      = to_lsb_q;
    assign bus.to_lsb_tag  = to_lsb_tag_q;
    assign bus.flush       = flush_q;
    assign bus.flush_pc    = flush_pc_q;
    assign bus.qry_ready   = qry_ready_w;
    assign bus.qry_data    = qry_data_w;

endmodule

// File: tb/tb_rob_mc.sv
// Directed self-checking bench for rob_mc with hand-computed expectations.
module tb_rob_mc;
    import rob_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;
    int   checks;
    int   errors;

    rob_mc_if #(.ROB_WIDTH(4), .COMMIT_W(2), .NQ(2)) bus ();

    rob_mc #(.ROB_WIDTH(4), .COMMIT_W(2), .NQ(2)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, waits past the edge, then idles the inputs.
    task automatic applyStimulus(input logic a_v, input logic [2:0] a_op, input logic [4:0] a_rd,
                                 input logic r_v, input logic [3:0] r_tag, input logic [31:0] r_data,
                                 input logic [31:0] r_jump, input logic r_redir,
                                 input logic l_v, input logic [3:0] l_tag, input logic [31:0] l_data);
        bus.alloc_valid    = a_v;
        bus.alloc_op       = a_op;
        bus.alloc_rd       = a_rd;
        bus.rs_wb_valid    = r_v;
        bus.rs_wb_tag      = r_tag;
        bus.rs_wb_wdata    = r_data;
        bus.rs_wb_jump     = r_jump;
        bus.rs_wb_redirect = r_redir;
        bus.lsb_wb_valid   = l_v;
        bus.lsb_wb_tag     = l_tag;
        bus.lsb_wb_wdata   = l_data;
        @(posedge clk);
        #1;
        bus.alloc_valid    = 1'b0;
        bus.rs_wb_valid    = 1'b0;
        bus.lsb_wb_valid   = 1'b0;
    endtask

    task automatic allocOne(input logic [2:0] op, input logic [4:0] rd);
        applyStimulus(1'b1, op, rd, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic rsWb(input logic [3:0] tag, input logic [31:0] data, input logic [31:0] jump);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, tag, data, jump, 1'b0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rdy    = 1'b1;
        rst_n  = 1'b0;
        bus.alloc_valid = 1'b0; bus.alloc_op = 3'd0; bus.alloc_rd = 5'd0;
        bus.rs_wb_valid = 1'b0; bus.rs_wb_tag = 4'd0; bus.rs_wb_wdata = 32'h0;
        bus.rs_wb_jump = 32'h0; bus.rs_wb_redirect = 1'b0;
        bus.lsb_wb_valid = 1'b0; bus.lsb_wb_tag = 4'd0; bus.lsb_wb_wdata = 32'h0;
        bus.qry_tag = 8'h10;

        #3;
        checkOutput("rst_cm_valid", bus.cm_valid, 0);
        checkOutput("rst_flush", bus.flush, 0);
        checkOutput("rst_to_lsb", bus.to_lsb, 0);
        checkOutput("rst_count", bus.count, 0);
        checkOutput("rst_alloc_ready", bus.alloc_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full, then retire two and watch the tail wrap.
        for (int i = 0; i < 16; i++) begin
            checkOutput("fill_tag", bus.alloc_tag, i);
            allocOne(OP_WRITE, 5'(i + 1));
        end
        checkOutput("full_count", bus.count, 16);
        checkOutput("full_alloc_ready", bus.alloc_ready, 0);
        applyStimulus(1'b1, OP_WRITE, 5'd30, 1'b1, 4'd1, 32'h11, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        checkOutput("full_drop_count", bus.count, 16);
        applyStimulus(1'b1, OP_WRITE, 5'd30, 1'b1, 4'd0, 32'h10, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        checkOutput("full_no_commit", bus.cm_valid, 0);
        applyStimulus(1'b1, OP_WRITE, 5'd30, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        checkOutput("full_cm_valid", bus.cm_valid, 2'b11);
        checkOutput("full_cm_rd", bus.cm_rd, {5'd2, 5'd1});
        checkOutput("full_cm_wdata", bus.cm_wdata, {32'h11, 32'h10});
        checkOutput("full_no_credit_count", bus.count, 14);
        checkOutput("full_alloc_ready_back", bus.alloc_ready, 1);
        checkOutput("wrap_tag0", bus.alloc_tag, 0);
        allocOne(OP_WRITE, 5'd17);
        checkOutput("wrap_tag1", bus.alloc_tag, 1);
        checkOutput("wrap_count", bus.count, 15);
        resetDut();

        // Out-of-order writeback, in-order two-wide retirement.
        allocOne(OP_WRITE, 5'd1);
        allocOne(OP_WRITE, 5'd2);
        allocOne(OP_WRITE, 5'd3);
        checkOutput("ord_count", bus.count, 3);
        rsWb(4'd2, 32'd30, 32'h0);
        checkOutput("ord_wait0", bus.cm_valid, 0);
        rsWb(4'd1, 32'd20, 32'h0);
        checkOutput("ord_wait1", bus.cm_valid, 0);
        rsWb(4'd0, 32'd10, 32'h0);
        checkOutput("ord_wait2", bus.cm_valid, 0);
        idleCycle();
        checkOutput("ord_pair_valid", bus.cm_valid, 2'b11);
        checkOutput("ord_pair_rd", bus.cm_rd, {5'd2, 5'd1});
        checkOutput("ord_pair_wdata", bus.cm_wdata, {32'd20, 32'd10});
        checkOutput("ord_pair_tag", bus.cm_tag, {4'd1, 4'd0});
        idleCycle();
        checkOutput("ord_last_valid", bus.cm_valid, 2'b01);
        checkOutput("ord_last_rd", bus.cm_rd, {5'd0, 5'd3});
        checkOutput("ord_last_wdata", bus.cm_wdata, {32'd0, 32'd30});
        checkOutput("ord_last_tag", bus.cm_tag, {4'd0, 4'd2});
        idleCycle();
        checkOutput("ord_pulse_end", bus.cm_valid, 0);

        // Store retires alone; the younger write follows a cycle later.
        allocOne(OP_STORE, 5'd9);
        allocOne(OP_WRITE, 5'd5);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 4'd3, 32'h99, 32'h0, 1'b0, 1'b1, 4'd4, 32'h55);
        idleCycle();
        checkOutput("st_cm_valid", bus.cm_valid, 2'b01);
        checkOutput("st_to_lsb", bus.to_lsb, 1);
        checkOutput("st_to_lsb_tag", bus.to_lsb_tag, 3);
        checkOutput("st_cm_rd", bus.cm_rd, 0);
        checkOutput("st_cm_wdata", bus.cm_wdata, 0);
        idleCycle();
        checkOutput("st_wr_valid", bus.cm_valid, 2'b01);
        checkOutput("st_to_lsb_pulse", bus.to_lsb, 0);
        checkOutput("st_wr_rd", bus.cm_rd, 5);
        checkOutput("st_wr_wdata", bus.cm_wdata, 32'h55);
        checkOutput("st_wr_tag", bus.cm_tag, 4);
        resetDut();

        // Jump at tag 1 flushes; ready younger entries never retire.
        allocOne(OP_WRITE, 5'd7);
        allocOne(OP_JUMP, 5'd8);
        allocOne(OP_WRITE, 5'd9);
        allocOne(OP_WRITE, 5'd10);
        rsWb(4'd3, 32'd3, 32'h0);
        rsWb(4'd2, 32'd2, 32'h0);
        rsWb(4'd1, 32'h44, 32'h1000);
        rsWb(4'd0, 32'h70, 32'h0);
        checkOutput("jmp_wait", bus.cm_valid, 0);
        applyStimulus(1'b1, OP_WRITE, 5'd11, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        checkOutput("jmp_flush", bus.flush, 1);
        checkOutput("jmp_flush_pc", bus.flush_pc, 32'h1000);
        checkOutput("jmp_cm_valid", bus.cm_valid, 2'b11);
        checkOutput("jmp_cm_rd", bus.cm_rd, {5'd0, 5'd7});
        checkOutput("jmp_cm_wdata", bus.cm_wdata, {32'd0, 32'h70});
        checkOutput("jmp_count", bus.count, 0);
        checkOutput("jmp_alloc_ready", bus.alloc_ready, 0);
        idleCycle();
        checkOutput("jmp_flush_pulse", bus.flush, 0);
        checkOutput("jmp_after_valid", bus.cm_valid, 0);
        checkOutput("jmp_after_ready", bus.alloc_ready, 1);
        checkOutput("jmp_after_tag", bus.alloc_tag, 0);
        idleCycle();
        checkOutput("jmp_younger_never", bus.cm_valid, 0);

        // Load needs LSB data; RS writeback alone does not make it ready.
        allocOne(OP_LOAD, 5'd12);
        rsWb(4'd0, 32'h1234, 32'h0);
        checkOutput("ld_qry_not_ready", bus.qry_ready, 2'b00);
        idleCycle();
        idleCycle();
        checkOutput("ld_no_commit", bus.cm_valid, 0);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd0, 32'hDEAD);
        checkOutput("ld_qry_ready", bus.qry_ready, 2'b01);
        checkOutput("ld_qry_data", bus.qry_data[31:0], 32'hDEAD);
        checkOutput("ld_wait", bus.cm_valid, 0);
        idleCycle();
        checkOutput("ld_cm_valid", bus.cm_valid, 2'b01);
        checkOutput("ld_cm_rd", bus.cm_rd, 12);
        checkOutput("ld_cm_wdata", bus.cm_wdata, 32'hDEAD);
        checkOutput("ld_qry_retired", bus.qry_ready, 2'b00);

        // rdy low freezes state.
        rdy = 1'b0;
        allocOne(OP_WRITE, 5'd20);
        checkOutput("rdy_freeze_count", bus.count, 0);
        rdy = 1'b1;

        // Asynchronous reset with commits pending.
        allocOne(OP_WRITE, 5'd20);
        allocOne(OP_WRITE, 5'd21);
        allocOne(OP_WRITE, 5'd22);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 4'd1, 32'hA1, 32'h0, 1'b0, 1'b1, 4'd2, 32'hA2);
        idleCycle();
        checkOutput("mid_pre_valid", bus.cm_valid, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_cm_valid", bus.cm_valid, 0);
        checkOutput("mid_cm_rd", bus.cm_rd, 0);
        checkOutput("mid_cm_wdata", bus.cm_wdata, 0);
        checkOutput("mid_cm_tag", bus.cm_tag, 0);
        checkOutput("mid_count", bus.count, 0);
        checkOutput("mid_flush", bus.flush, 0);
        checkOutput("mid_to_lsb", bus.to_lsb, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("mid_alloc_tag", bus.alloc_tag, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_mc.md
# rob_mc

Parametrised multi-commit reorder buffer, successor to the single-commit ROB. Sits between decoder/RS/LSB and the register file. It allocates tags in program order, accepts out-of-order writeback from the RS and LSB, and retires up to COMMIT_W entries per cycle in order. It also issues store-commit tokens to the LSB, raises a flush with a redirect PC on a committed redirect, and serves combinational operand queries for RS dispatch.

## Interface
- ROB_WIDTH, 4, tag width; depth DEPTH = 2**ROB_WIDTH
- COMMIT_W, 2, max retirements per cycle (1..4)
- NQ, 2, number of operand query ports
- clk_in  in  1  clock, all state on posedge
- rst_n_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global clock enable; when low, all state holds
- alloc_valid  in  1  decoder requests an entry
- alloc_op  in  3  WRITE/JUMP/BOTH/LOAD/STORE/NOTHING
- alloc_rd  in  5  destination register
- alloc_ready  out  1  an entry is available (comb.: count<DEPTH and !flush)
- alloc_tag  out  ROB_WIDTH  tag assigned if allocated this cycle (= tail index)
- rs_wb_valid, rs_wb_tag, rs_wb_wdata[31:0], rs_wb_jump[31:0], rs_wb_redirect  in  RS result
- lsb_wb_valid, lsb_wb_tag, lsb_wb_wdata[31:0]  in  load data return
- cm_valid  out  COMMIT_W  per-slot retire strobe, slot 0 oldest
- cm_rd  out  5*COMMIT_W  per-slot rd, 0 when no register write
- cm_wdata  out  32*COMMIT_W  per-slot data
- cm_tag  out  ROB_WIDTH*COMMIT_W  per-slot tag (for RS dependency clear)
- to_lsb, to_lsb_tag  out  1, ROB_WIDTH  store commit token
- flush, flush_pc  out  1, 32  pipeline clear and redirect target
- qry_tag  in  ROB_WIDTH*NQ; qry_ready  out  NQ; qry_data  out  32*NQ
- count  out  ROB_WIDTH+1  occupied entries

## Operation
- Pointers head/tail are ROB_WIDTH+1 bits with a wrap bit. Empty: head==tail. Full: indices equal and wrap bits differ. count = tail-head, modulo 2**(ROB_WIDTH+1).
- Alloc when alloc_valid && alloc_ready: entry[tail] gets valid=1, ready=0, op, rd, redirect=0. tail increments.
- rs_wb: sets wdata, jump, redirect. Sets ready=1 unless op==LOAD.
- lsb_wb: sets wdata, ready=1. Same tag on both ports in one cycle is illegal; lsb wins.
- Commit scan from head over slots i=0..COMMIT_W-1. Slot i retires iff entry head+i is valid and ready and every slot before it retired. The scan stops after:
  - a STORE, so at most one store per cycle;
  - an entry with redirect=1, or an op of JUMP or BOTH.
- Register write per slot: cm_rd=rd for WRITE/LOAD/BOTH. For JUMP/STORE/NOTHING, cm_rd=0 and cm_wdata=0.
- Store retire: to_lsb=1, to_lsb_tag=its tag.
- Redirect retire (redirect=1, or op JUMP/BOTH): flush=1, flush_pc=jump. At the same edge head, tail and every valid bit clear to 0.
- Query: qry_ready[k] = valid&ready of entry qry_tag[k]; qry_data[k] = its wdata. Purely combinational, no same-cycle writeback bypass.

## Timing
- Reset (async, rst_n_in=0): head=tail=0, all valid=0, and every output register is 0: cm_valid, cm_rd, cm_wdata, cm_tag, to_lsb, to_lsb_tag, flush, flush_pc.
- Writeback at edge N makes the entry eligible for commit at edge N+1. cm_* and to_lsb are registered and valid in cycle N+1→N+2. Minimum wb-to-commit-visible latency is 2 cycles.
- cm_valid, to_lsb and flush are single-cycle pulses.
- flush is high for exactly one cycle. During that cycle alloc_ready=0, and wb and commit are ignored; normal operation resumes next cycle.
- Full with retirement in the same cycle: alloc_ready still 0, since there is no same-cycle credit.
- Alloc and commit can occur in the same cycle. Alloc into a slot freed in that cycle is not possible.
- A committed redirect with alloc_valid in the same cycle: the alloc is dropped.
- rdy_in low freezes everything and keeps output registers at their values. Pulses are not re-asserted.
- Pointer wrap from DEPTH-1 to 0 is seamless; the wrap bit toggles.

## Structure
- Shared package rob_pkg holds the op encodings (WRITE=0, JUMP=1, BOTH=2, LOAD=3, STORE=4, NOTHING=5) and the entry record (valid, ready, redirect, op, rd, wdata, jump).
- One sub-module, rob_commit_sel: combinational in-order prefix selector. It takes per-slot ready/op/redirect vectors and produces the retire mask, store slot and redirect slot.

## Test plan
- Alloc 3 WRITEs (rd 1,2,3), then rs_wb tags 2,1,0 with data 30,20,10. Required: slots 0 and 1 retire in one cycle (rd1=10, rd2=20), then rd3=30, in order.
- Fill to DEPTH=16. Required: alloc_ready=0 and count=16. Retire 2: alloc_ready returns next cycle; tail wraps and new tags are 0 and 1.
- STORE then WRITE, both ready. Required: the store retires alone (to_lsb=1 with its tag); the WRITE retires the next cycle.
- JUMP at tag 1 with jump=0x1000, younger entries ready. Required: flush=1 with flush_pc=0x1000 for one cycle, count=0, younger entries never retire.
- LOAD with rs_wb only: never retires. Then lsb_wb data 0xDEAD: retires with rd write 0xDEAD two cycles later. qry_ready goes 0→1 the cycle after lsb_wb.
- Assert rst_n_in low mid-stream with pending commits. Required: all outputs drop to 0 immediately and count=0.
